// File: rtl/syn_rst_pkg.sv
// Shared types and limits for the reset sequencer.
package syn_rst_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        WAIT_ACK,
        DONE
    } syn_rst_seq_st_t;

    localparam int SYN_RST_MAX_DOMAINS = 8;

endpackage

// File: rtl/syn_bit_sync.sv
// Single-bit flop-chain synchronizer with async reset and a synchronous clear.
module syn_bit_sync #(
    parameter int NO_OF_SYNC_STAGES = 2
) (
    input  logic clk_ir,
    input  logic rst_async_il,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [NO_OF_SYNC_STAGES-1:0] chain_reg;

    always_ff @(posedge clk_ir or negedge rst_async_il) begin
        if (!rst_async_il) begin
            chain_reg <= '0;
        end else if (clr) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[NO_OF_SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain_reg[NO_OF_SYNC_STAGES-1];

endmodule

// File: rtl/syn_rst_seq.sv
// Reset sequencer: holds all domain resets, then releases them one at a time on ack.
// Optional per-domain ack timeout is built when SYN_RST_SEQ_TIMEOUT_EN is defined.
module syn_rst_seq
    import syn_rst_pkg::*;
#(
    parameter int NUM_DOMAINS       = 4,
    parameter int HOLD_CYCLES       = 16,
    parameter int NO_OF_SYNC_STAGES = 2,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                   clk_ir,
    input  logic                   rst_async_il,
    input  logic                   sw_rst_req_i,
    input  logic [NUM_DOMAINS-1:0] rst_ack_i,
    output logic [NUM_DOMAINS-1:0] rst_o_l,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   timeout_o,
    output logic [2:0]             timeout_idx_o
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
    localparam bit CFG_OK = (NUM_DOMAINS >= 1) && (NUM_DOMAINS <= SYN_RST_MAX_DOMAINS) &&
                            (HOLD_CYCLES >= 1) && (HOLD_CYCLES <= 65535) &&
                            (NO_OF_SYNC_STAGES >= 2) && (TIMEOUT_CYCLES >= 1);

    if (!CFG_OK) begin : g_bad_cfg
        $error("syn_rst_seq: parameter out of legal range");
    end

    syn_rst_seq_st_t        state_reg;
    logic [HOLD_W-1:0]      hold_cnt_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [NUM_DOMAINS-1:0] rst_l_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic [NUM_DOMAINS-1:0] ack_sync;
    logic                   ack_cur;
    logic                   advance;

    // Each ack chain is held clear while its domain is in reset, so a stale or
    // constantly-high ack is only seen after a full synchronizer latency.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_ack_sync
            syn_bit_sync #(
                .NO_OF_SYNC_STAGES(NO_OF_SYNC_STAGES)
            ) u_sync (
                .clk_ir      (clk_ir),
                .rst_async_il(rst_async_il),
                .clr         (~rst_l_reg[gi]),
                .d           (rst_ack_i[gi]),
                .q           (ack_sync[gi])
            );
        end
    endgenerate

    assign ack_cur = ack_sync[idx_reg];

`ifdef SYN_RST_SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              timeout_reg;
    logic [IDX_W-1:0]  timeout_idx_reg;
    logic              wait_expired;

    assign wait_expired = (wait_cnt_reg == WAIT_LAST) && !ack_cur;
    assign advance      = ack_cur || wait_expired;

    always_ff @(posedge clk_ir or negedge rst_async_il) begin
        if (!rst_async_il) begin
            wait_cnt_reg    <= '0;
            timeout_reg     <= 1'b0;
            timeout_idx_reg <= '0;
        end else if (sw_rst_req_i) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else if (state_reg == RELEASE) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == WAIT_ACK) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
            if (wait_expired) begin
                timeout_reg <= 1'b1;
                if (!timeout_reg) begin
                    timeout_idx_reg <= idx_reg;
                end
            end
        end
    end

    assign timeout_o     = timeout_reg;
    assign timeout_idx_o = 3'(timeout_idx_reg);
`else
    assign advance       = ack_cur;
    assign timeout_o     = 1'b0;
    assign timeout_idx_o = 3'b000;
`endif

    always_ff @(posedge clk_ir or negedge rst_async_il) begin
        if (!rst_async_il) begin
            state_reg    <= HOLD;
            hold_cnt_reg <= '0;
            idx_reg      <= '0;
            rst_l_reg    <= '0;
            busy_reg     <= 1'b1;
            done_reg     <= 1'b0;
        end else if (sw_rst_req_i) begin
            state_reg    <= HOLD;
            hold_cnt_reg <= '0;
            idx_reg      <= '0;
            rst_l_reg    <= '0;
            busy_reg     <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                HOLD: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_reg <= RELEASE;
                        idx_reg   <= '0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                RELEASE: begin
                    rst_l_reg[idx_reg] <= 1'b1;
                    state_reg          <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (advance) begin
                        if (idx_reg == IDX_LAST) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            state_reg <= RELEASE;
                        end
                    end
                end
                DONE: begin
                    rst_l_reg <= '1;
                end
                default: begin
                    state_reg <= HOLD;
                end
            endcase
        end
    end

    assign rst_o_l = rst_l_reg;
    assign busy_o  = busy_reg;
    assign done_o  = done_reg;

endmodule

// File: doc/syn_rst_seq.md
Name: syn_rst_seq

Overview:
- Reset sequencer: the driving end of the clock/reset interface. It generates the reset signals that downstream clock/reset synchronizers consume.
- Takes one board-level async reset plus a software reset request. Drives NUM_DOMAINS active-low reset outputs, all asserted together and released one at a time in index order.
- Before releasing the next domain it waits for that domain's "out of reset" acknowledge.
- Sits in the top-level clock/reset block, clocked by the always-on reference clock.

Parameters:
- NUM_DOMAINS, 4: number of reset outputs/acks; legal range 1..8.
- HOLD_CYCLES, 16: minimum cycles all resets are held asserted; legal range 1..65535.
- NO_OF_SYNC_STAGES, 2: synchronizer depth on each rst_ack_i bit; minimum 2.
- TIMEOUT_CYCLES, 1024: ack wait limit per domain; used only with the optional feature.

Ports:
- clk_ir  input  1  always-on reference clock.
- rst_async_il  input  1  asynchronous, active-low reset.
- sw_rst_req_i  input  1  synchronous single-cycle request to re-run the full sequence.
- rst_ack_i  input  NUM_DOMAINS  per-domain "reset released" level, asynchronous to clk_ir; synchronized internally.
- rst_o_l  output  NUM_DOMAINS  active-low resets to downstream domains; bit i feeds domain i's synchronizer.
- busy_o  output  1  high while the sequence is running.
- done_o  output  1  high when all domains are released and acked.
- timeout_o  output  1  sticky flag: some domain failed to ack (optional feature only).
- timeout_idx_o  output  3  index of the first domain that timed out (optional feature only).

Behaviour:
- Reset values (rst_async_il low, applied immediately):
  - rst_o_l = all 0.
  - busy_o = 1, done_o = 0.
  - timeout_o = 0, timeout_idx_o = 0.
  - State = HOLD, hold counter = 0, domain index = 0, ack synchronizers = 0.
- Outputs are registered; rst_o_l never glitches high.
- Assertion is asynchronous via rst_async_il. All release edges are synchronous to clk_ir.
- State HOLD:
  - Hold counter increments each cycle.
  - When the counter reaches HOLD_CYCLES-1: go to RELEASE, index = 0.
  - All rst_o_l bits stay 0.
- State RELEASE:
  - Set rst_o_l[index] = 1 (registered, one cycle after entry). Go to WAIT_ACK, clear the wait counter.
- State WAIT_ACK:
  - Wait for the synchronized ack[index] = 1.
  - On ack with index = NUM_DOMAINS-1: go to DONE.
  - On ack otherwise: index++ and go to RELEASE.
  - Latency from ack edge to the next release edge = NO_OF_SYNC_STAGES + 2 cycles.
- State DONE:
  - busy_o = 0, done_o = 1, all rst_o_l = 1.
- sw_rst_req_i:
  - Sampled in every state.
  - When high: next cycle all rst_o_l = 0, busy_o = 1, done_o = 0, hold counter = 0, index = 0, state = HOLD. timeout_o is cleared.
  - A request during HOLD restarts the hold count.
- Simultaneous events:
  - sw_rst_req_i has priority over ack and over counter terminal events in the same cycle.
  - rst_async_il overrides everything.
- Ack behaviour:
  - An ack already high on entry to WAIT_ACK is accepted after synchronizer latency; no edge detection is done.
  - A synchronized ack dropping for an already-released domain is ignored; there is no re-sequencing.
- Released domains stay released (rst_o_l bits stay 1) during later waits.
- Counter widths:
  - Hold counter width = $clog2(HOLD_CYCLES+1).
  - Index width = $clog2(NUM_DOMAINS) (minimum 1), zero-extended onto timeout_idx_o.

Optional Feature:
- Macro: SYN_RST_SEQ_TIMEOUT_EN.
- Defined:
  - The wait counter increments in WAIT_ACK.
  - At TIMEOUT_CYCLES-1 without ack: timeout_o = 1 (sticky until reset or sw_rst_req_i). timeout_idx_o = index, captured only on the first timeout.
  - The FSM then proceeds as if the ack arrived (index++ or DONE).
- Undefined:
  - No wait counter is built. WAIT_ACK waits indefinitely.
  - timeout_o and timeout_idx_o are tied to 0.

Decomposition:
- Package syn_rst_pkg:
  - typedef enum logic [1:0] syn_rst_seq_st_t {HOLD, RELEASE, WAIT_ACK, DONE}.
  - localparam SYN_RST_MAX_DOMAINS = 8.
- Sub-module syn_bit_sync:
  - Parameter NO_OF_SYNC_STAGES; one instance per ack bit (generate loop).
  - Flop chain reset to 0 by rst_async_il.

Test Plan:
1. Defaults. Drop rst_async_il, release at t0; ack each domain 3 cycles after its release.
   -> rst_o_l stays 0000 for 16 cycles, then goes 0001, 0011, 0111, 1111.
   -> Gap between releases = 3 + 4 cycles; done_o rises 1 cycle after the last synchronized ack.
2. In DONE, pulse sw_rst_req_i for 1 cycle.
   -> Next cycle rst_o_l = 0000, busy_o = 1, done_o = 0; the full sequence reruns identically.
3. Hold rst_ack_i = 1111 constantly through reset.
   -> Each release is spaced by NO_OF_SYNC_STAGES + 2 = 4 cycles; done_o follows.
4. Assert rst_async_il mid-WAIT_ACK with index = 2.
   -> rst_o_l = 0000 combinationally-asynchronously; the full restart runs from HOLD after release.
5. With SYN_RST_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 32, never ack domain 1.
   -> After 32 cycles timeout_o = 1, timeout_idx_o = 1; domains 2 and 3 still release; done_o = 1.
   -> A later sw_rst_req_i clears timeout_o.
6. sw_rst_req_i in the same cycle as the domain 0 synchronized ack.
   -> Request wins: state = HOLD, index = 0, rst_o_l = 0000.
